// File: rtl/sensor_sampler.sv
// sensor_sampler: synchronizes N asynchronous sensor lines, samples them on a
// programmable prescaler tick and debounces each bit independently, driving a
// registered clean vector plus a valid flag and a change strobe.
module sensor_sampler #(
    parameter int unsigned N          = 5,
    parameter int unsigned SAMPLE_DIV = 1000,
    parameter int unsigned STABLE_CNT = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic [N-1:0] sensor_in,
    output logic [N-1:0] bits,
    output logic         bits_valid,
    output logic         update
);

    localparam int unsigned PW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int unsigned CW = $clog2(STABLE_CNT + 1);

    localparam logic [PW-1:0] PRESC_MAX  = PW'(SAMPLE_DIV - 1);
    localparam logic [CW-1:0] CNT_SAT    = CW'(STABLE_CNT);
    localparam logic [CW-1:0] CNT_COMMIT = CW'(STABLE_CNT - 1);

    typedef enum logic [0:0] {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    logic [N-1:0]          sync1_q, sync2_q;
    logic [PW-1:0]         presc_q, presc_d;
    logic                  tick;
    logic [N-1:0]          cand_q, cand_d;
    logic [N-1:0][CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]          seen_q, seen_d;
    logic [N-1:0]          bits_q, bits_d;
    state_t                state_q;
    logic                  valid_q;
    logic                  update_q;

    // Two-flop synchronizer per sensor line; keeps tracking while disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sensor_in;
            sync2_q <= sync1_q;
        end
    end

    // Sample-tick prescaler: counts enabled clocks, holds while disabled.
    always_comb begin
        tick    = enable && (presc_q == PRESC_MAX);
        presc_d = presc_q;
        if (enable) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end
    end

    // Per-bit debounce: track a candidate level and how many ticks it has held.
    // The count saturates so a stable run commits exactly once.
    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        bits_d = bits_q;
        seen_d = seen_q;
        if (tick) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (sync2_q[i] == cand_q[i]) begin
                    if (cnt_q[i] != CNT_SAT) begin
                        cnt_d[i] = cnt_q[i] + CW'(1);
                    end
                    if (cnt_q[i] == CNT_COMMIT) begin
                        bits_d[i] = sync2_q[i];
                        seen_d[i] = 1'b1;
                    end
                end else begin
                    cand_d[i] = sync2_q[i];
                    cnt_d[i]  = CW'(1);
                end
            end
        end
    end

    // Prescaler and debounce state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            cand_q  <= '0;
            cnt_q   <= '0;
            seen_q  <= '0;
            bits_q  <= '0;
        end else begin
            presc_q <= presc_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            seen_q  <= seen_d;
            bits_q  <= bits_d;
        end
    end

    // FILL waits for every bit to commit once; RUN strobes update on each change.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FILL;
            valid_q  <= 1'b0;
            update_q <= 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    update_q <= 1'b0;
                    if (&seen_d) begin
                        state_q  <= RUN;
                        valid_q  <= 1'b1;
                        update_q <= 1'b1;
                    end
                end
                RUN: begin
                    valid_q  <= 1'b1;
                    update_q <= (bits_d != bits_q);
                end
                default: begin
                    state_q  <= FILL;
                    valid_q  <= 1'b0;
                    update_q <= 1'b0;
                end
            endcase
        end
    end

    assign bits       = bits_q;
    assign bits_valid = valid_q;
    assign update     = update_q;

endmodule

// File: tb/tb_sensor_sampler.sv
// Directed testbench for sensor_sampler with SAMPLE_DIV=4, STABLE_CNT=3.
// Ticks land on every 4th clock edge after reset release while enabled.
module tb_sensor_sampler;

    localparam int unsigned N = 5;

    logic         clk;
    logic         rst;
    logic         enable;
    logic [N-1:0] sensor_in;
    logic [N-1:0] bits;
    logic         bits_valid;
    logic         update;

    int tests;
    int fails;

    sensor_sampler #(
        .N          (N),
        .SAMPLE_DIV (4),
        .STABLE_CNT (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .sensor_in  (sensor_in),
        .bits       (bits),
        .bits_valid (bits_valid),
        .update     (update)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        enable    = 1'b1;
        sensor_in = '0;
        repeat (3) step();
        tests++;
        if (bits !== 5'b00000) begin
            fails++;
            $display("FAIL reset_bits: got %b expected %b", bits, 5'b00000);
        end
        tests++;
        if (bits_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_valid: got %b expected 0", bits_valid);
        end
        tests++;
        if (update !== 1'b0) begin
            fails++;
            $display("FAIL reset_update: got %b expected 0", update);
        end
    endtask

    // Called at a negedge with rst high; releases reset and checks 13 edges.
    task automatic test_startup();
        logic [N-1:0] exp_bits;
        logic         exp_valid;
        logic         exp_upd;
        sensor_in = 5'b10110;
        rst       = 1'b0;
        enable    = 1'b1;
        for (int i = 1; i <= 13; i++) begin
            step();
            exp_bits  = (i >= 12) ? 5'b10110 : 5'b00000;
            exp_valid = (i >= 12);
            exp_upd   = (i == 12);
            tests++;
            if (bits !== exp_bits || bits_valid !== exp_valid || update !== exp_upd) begin
                fails++;
                $display("FAIL startup edge %0d: bits=%b valid=%b upd=%b expected bits=%b valid=%b upd=%b",
                         i, bits, bits_valid, update, exp_bits, exp_valid, exp_upd);
            end
        end
    endtask

    // Bit0 high for one tick period only: must be rejected.
    task automatic test_glitch();
        sensor_in = 5'b10111;
        for (int i = 14; i <= 33; i++) begin
            step();
            tests++;
            if (bits !== 5'b10110 || update !== 1'b0 || bits_valid !== 1'b1) begin
                fails++;
                $display("FAIL glitch edge %0d: bits=%b upd=%b valid=%b expected bits=10110 upd=0 valid=1",
                         i, bits, update, bits_valid);
            end
            if (i == 17) sensor_in = 5'b10110;
        end
    endtask

    // All five bits flip together: one commit edge, one update pulse.
    task automatic test_back_to_back();
        logic [N-1:0] exp_bits;
        logic         exp_upd;
        sensor_in = 5'b01001;
        for (int i = 34; i <= 45; i++) begin
            step();
            exp_bits = (i >= 44) ? 5'b01001 : 5'b10110;
            exp_upd  = (i == 44);
            tests++;
            if (bits !== exp_bits || update !== exp_upd) begin
                fails++;
                $display("FAIL change edge %0d: bits=%b upd=%b expected bits=%b upd=%b",
                         i, bits, update, exp_bits, exp_upd);
            end
        end
    endtask

    // Freeze sampling with prescaler at 1 while inputs wander, then resume.
    task automatic test_enable_hold();
        logic [N-1:0] exp_bits;
        logic         exp_upd;
        enable    = 1'b0;
        sensor_in = 5'b11111;
        for (int i = 46; i <= 65; i++) begin
            step();
            tests++;
            if (bits !== 5'b01001 || update !== 1'b0) begin
                fails++;
                $display("FAIL hold edge %0d: bits=%b upd=%b expected bits=01001 upd=0",
                         i, bits, update);
            end
            if (i == 50) sensor_in = 5'b00000;
            if (i == 55) sensor_in = 5'b10100;
        end
        enable = 1'b1;
        for (int i = 66; i <= 77; i++) begin
            step();
            exp_bits = (i >= 76) ? 5'b10100 : 5'b01001;
            exp_upd  = (i == 76);
            tests++;
            if (bits !== exp_bits || update !== exp_upd) begin
                fails++;
                $display("FAIL resume edge %0d: bits=%b upd=%b expected bits=%b upd=%b",
                         i, bits, update, exp_bits, exp_upd);
            end
        end
    endtask

    // One-cycle reset while running, then the startup sequence repeats.
    task automatic test_reset_mid();
        rst = 1'b1;
        step();
        tests++;
        if (bits !== 5'b00000 || bits_valid !== 1'b0 || update !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid: bits=%b valid=%b upd=%b expected bits=00000 valid=0 upd=0",
                     bits, bits_valid, update);
        end
        test_startup();
    endtask

    // Input toggling every two ticks never commits anything.
    task automatic test_toggle();
        rst       = 1'b1;
        sensor_in = 5'b01010;
        repeat (2) step();
        rst = 1'b0;
        for (int i = 1; i <= 96; i++) begin
            step();
            tests++;
            if (bits !== 5'b00000 || bits_valid !== 1'b0 || update !== 1'b0) begin
                fails++;
                $display("FAIL toggle edge %0d: bits=%b valid=%b upd=%b expected bits=00000 valid=0 upd=0",
                         i, bits, bits_valid, update);
            end
            if (i % 8 == 6) sensor_in = ~sensor_in;
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_startup();
        test_glitch();
        test_back_to_back();
        test_enable_hold();
        test_reset_mid();
        test_toggle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
